// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer: opcode encodings,
// opcode legality check and the sequencer FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_PLUS    = 3'd0;
  localparam logic [2:0] OP_MINUS   = 3'd1;
  localparam logic [2:0] OP_BAND    = 3'd2;
  localparam logic [2:0] OP_BOR     = 3'd3;
  localparam logic [2:0] OP_UNEGATE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_e;

  // Opcodes 5-7 are reserved and answered with an error response.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_UNEGATE);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU driven by alu_cmd_sequencer; results wrap modulo 2^WIDTH.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Operation select; unegate is the bitwise inverse of a and ignores b.
  always_comb begin
    y = {WIDTH{1'b0}};
    case (opcode)
      OP_PLUS:    y = a + b;
      OP_MINUS:   y = a - b;
      OP_BAND:    y = a & b;
      OP_BOR:     y = a | b;
      OP_UNEGATE: y = ~a;
      default:    y = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command/response sequencer in front of a combinational ALU, with accumulator chaining.
// Optional result flags (rsp_zero, rsp_neg) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  input  logic             acc_clr,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
`ifdef ALU_SEQ_FLAGS_EN
 ,output logic             rsp_zero,
  output logic             rsp_neg
`endif
);

  localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  seq_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [2:0]       alu_opcode_nxt;
  logic [WIDTH-1:0] alu_a_nxt, alu_b_nxt, rsp_data_nxt;
  logic             rsp_valid_nxt, rsp_err_nxt;
`ifdef ALU_SEQ_FLAGS_EN
  logic             rsp_zero_nxt, rsp_neg_nxt;
`endif

  // Next-state and next-output decode; every register holds unless a transition updates it.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    acc_nxt        = acc_clr ? {WIDTH{1'b0}} : acc;
    alu_opcode_nxt = alu_opcode;
    alu_a_nxt      = alu_a;
    alu_b_nxt      = alu_b;
    rsp_valid_nxt  = rsp_valid;
    rsp_data_nxt   = rsp_data;
    rsp_err_nxt    = rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
    rsp_zero_nxt   = rsp_zero;
    rsp_neg_nxt    = rsp_neg;
`endif
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (op_is_legal(cmd_opcode)) begin
            alu_opcode_nxt = cmd_opcode;
            alu_a_nxt      = cmd_chain ? acc : cmd_a;
            alu_b_nxt      = cmd_b;
            cnt_nxt        = CNT_LOAD;
            state_nxt      = ST_ISSUE;
          end else begin
            rsp_data_nxt   = {WIDTH{1'b0}};
            rsp_err_nxt    = 1'b1;
            rsp_valid_nxt  = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            rsp_zero_nxt   = 1'b0;
            rsp_neg_nxt    = 1'b0;
`endif
            state_nxt      = ST_RESP;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A capture overrides a simultaneous acc_clr.
        if (cnt == CNT_ZERO) begin
          rsp_data_nxt  = alu_out;
          acc_nxt       = alu_out;
          rsp_err_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
          rsp_zero_nxt  = (alu_out == {WIDTH{1'b0}});
          rsp_neg_nxt   = alu_out[WIDTH-1];
`endif
          state_nxt     = ST_RESP;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end else begin
          rsp_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= CNT_ZERO;
      acc        <= {WIDTH{1'b0}};
      cmd_ready  <= 1'b0;
      alu_opcode <= 3'd0;
      alu_a      <= {WIDTH{1'b0}};
      alu_b      <= {WIDTH{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_data   <= {WIDTH{1'b0}};
      rsp_err    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      cmd_ready  <= (state_nxt == ST_IDLE);
      alu_opcode <= alu_opcode_nxt;
      alu_a      <= alu_a_nxt;
      alu_b      <= alu_b_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_data   <= rsp_data_nxt;
      rsp_err    <= rsp_err_nxt;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero   <= rsp_zero_nxt;
      rsp_neg    <= rsp_neg_nxt;
`endif
    end
  end

endmodule
